// File: rtl/trace_pkg.sv
// Shared types and constants for the trace buffer: FSM states, buffer modes and the
// default vector shape used by the packer.
package trace_pkg;

    typedef enum logic [1:0] {StCapture, StRead, StPresent} state_e;

    localparam logic MODE_CIRCULAR = 1'b0;
    localparam logic MODE_STOP     = 1'b1;

    localparam int unsigned VEC_N     = 8;
    localparam int unsigned VEC_WIDTH = 32;

    typedef logic [VEC_N-1:0][VEC_WIDTH-1:0] vector_t;

endpackage

// File: rtl/trace_buffer_if.sv
// Bus bundle for the trace buffer: capture stream from the packer, config bus, drain handshake
// and status. The master side is whoever drives capture/config/drain (packer + host).
interface trace_buffer_if #(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                             tracing;
    logic                             valid_in;
    logic [N-1:0][DATA_WIDTH-1:0]     vector_in;
    logic [7:0]                       configId;
    logic [7:0]                       configData;
    logic                             drain_req;
    logic                             ready_in;
    logic [N-1:0][DATA_WIDTH-1:0]     vector_out;
    logic                             valid_out;
    logic [CW-1:0]                    count_out;
    logic                             overflow;
    logic                             busy;
    logic                             done;

    modport master (
        output tracing, valid_in, vector_in, configId, configData, drain_req, ready_in,
        input  vector_out, valid_out, count_out, overflow, busy, done
    );

    modport slave (
        input  tracing, valid_in, vector_in, configId, configData, drain_req, ready_in,
        output vector_out, valid_out, count_out, overflow, busy, done
    );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port storage for the trace buffer: one write port, one read port with a
// registered output. No reset so it maps onto block RAM.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/trace_buffer.sv
// Captures packer vectors into a circular buffer while tracing, then replays them oldest-first
// over a valid/ready handshake on request. Mode (overwrite vs stop-when-full) set via config bus.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned N                  = 8,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned DEPTH              = 16,
    parameter logic [7:0]  PERSONAL_CONFIG_ID = 8'd0,
    parameter bit          INITIAL_MODE       = 1'b0
) (
    input logic           clk,
    input logic           reset,
    trace_buffer_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            mode_q, mode_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;

    logic            full;
    logic            wr_req;
    logic            handshake;
    logic            ram_we;
    logic            ram_re;
    logic [N*DATA_WIDTH-1:0] ram_rdata;

    assign full      = (count_q == CW'(DEPTH));
    assign wr_req    = (state_q == StCapture) && bus.tracing && bus.valid_in;
    assign handshake = (state_q == StPresent) && bus.ready_in;
    // When full in stop mode the incoming vector is dropped rather than written.
    assign ram_we    = wr_req && (!full || (mode_q == MODE_CIRCULAR));
    assign ram_re    = (state_q == StRead);

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (N * DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (bus.vector_in),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StCapture;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCapture: begin
                if (bus.drain_req && !bus.tracing && (count_q != '0)) begin
                    state_d = StRead;
                end
            end
            StRead:    state_d = StPresent;
            StPresent: begin
                if (bus.ready_in) begin
                    state_d = (count_q > CW'(1)) ? StRead : StCapture;
                end
            end
            default:   state_d = StCapture;
        endcase
    end

    always_comb begin
        bus.valid_out  = (state_q == StPresent);
        bus.busy       = (state_q != StCapture);
        // RAM output is not reset, so gate it to keep vector_out at zero outside PRESENT.
        bus.vector_out = (state_q == StPresent) ? ram_rdata : '0;
        bus.count_out  = count_q;
        bus.overflow   = overflow_q;
        bus.done       = done_q;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        mode_d     = mode_q;
        if (bus.configId == PERSONAL_CONFIG_ID) begin
            mode_d = bus.configData[0];
        end
        if (wr_req) begin
            if (!full) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end else begin
                overflow_d = 1'b1;
                if (mode_q == MODE_CIRCULAR) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
        end
        if (handshake) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
            done_d   = (count_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mode_q     <= INITIAL_MODE;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus randomized capture/drain rounds
// compared against a queue-based model of the buffer.
module tb_trace_buffer;
    import trace_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    trace_buffer_if #(.N(VEC_N), .DATA_WIDTH(VEC_WIDTH), .DEPTH(DEPTH)) tb_if ();

    trace_buffer #(
        .N                  (VEC_N),
        .DATA_WIDTH         (VEC_WIDTH),
        .DEPTH              (DEPTH),
        .PERSONAL_CONFIG_ID (8'd0),
        .INITIAL_MODE       (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tb_if)
    );

    int      n_checks = 0;
    int      n_errors = 0;
    vector_t model_q[$];
    bit      model_mode;
    bit      model_ovf;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vector_t make_vec(input int unsigned lane0);
        vector_t v;
        for (int i = 0; i < VEC_N; i++) v[i] = $urandom;
        v[0] = lane0;
        return v;
    endfunction

    // Reference: bounded FIFO; when full, circular drops the oldest, stop drops the newest.
    function automatic void model_push(input vector_t v);
        if (model_q.size() < DEPTH) begin
            model_q.push_back(v);
        end else begin
            model_ovf = 1'b1;
            if (!model_mode) begin
                model_q.delete(0);
                model_q.push_back(v);
            end
        end
    endfunction

    task automatic check_model(input string tag);
        check_eq({tag, "_count"}, 256'(tb_if.count_out), 256'(model_q.size()));
        check_eq({tag, "_ovf"}, 256'(tb_if.overflow), 256'(model_ovf));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_q.delete();
        model_mode = 1'b0;
        model_ovf  = 1'b0;
    endtask

    task automatic set_mode(input bit m);
        tb_if.configId   = 8'd0;
        tb_if.configData = {7'd0, m};
        step();
        tb_if.configId   = 8'hFF;
        model_mode = m;
    endtask

    task automatic capture_seq(input int unsigned first, input int n);
        for (int i = 0; i < n; i++) begin
            vector_t v;
            v = make_vec(first + i);
            tb_if.tracing   = 1'b1;
            tb_if.valid_in  = 1'b1;
            tb_if.vector_in = v;
            step();
            model_push(v);
        end
        tb_if.valid_in = 1'b0;
    endtask

    // Drains everything the model holds; caller guarantees a non-empty buffer.
    task automatic drain(input int stall, input bit noise);
        int      n;
        vector_t exp;
        n = model_q.size();
        tb_if.tracing   = 1'b0;
        tb_if.valid_in  = 1'b0;
        tb_if.ready_in  = (stall == 0);
        tb_if.drain_req = 1'b1;
        step();
        tb_if.drain_req = 1'b0;
        if (noise) begin
            tb_if.tracing   = 1'b1;
            tb_if.valid_in  = 1'b1;
            tb_if.vector_in = make_vec(999);
        end
        for (int k = 0; k < n; k++) begin
            exp = model_q[0];
            check_eq("gap_valid", 256'(tb_if.valid_out), 256'(0));
            check_eq("gap_busy", 256'(tb_if.busy), 256'(1));
            check_eq("gap_done", 256'(tb_if.done), 256'(0));
            step();
            check_eq("valid", 256'(tb_if.valid_out), 256'(1));
            check_eq("data", 256'(tb_if.vector_out), 256'(exp));
            check_eq("count", 256'(tb_if.count_out), 256'(n - k));
            if (k == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    step();
                    check_eq("hold_valid", 256'(tb_if.valid_out), 256'(1));
                    check_eq("hold_data", 256'(tb_if.vector_out), 256'(exp));
                    check_eq("hold_count", 256'(tb_if.count_out), 256'(n));
                end
                tb_if.ready_in = 1'b1;
            end
            step();
            model_q.delete(0);
        end
        tb_if.tracing  = 1'b0;
        tb_if.valid_in = 1'b0;
        check_eq("done", 256'(tb_if.done), 256'(1));
        check_eq("end_busy", 256'(tb_if.busy), 256'(0));
        check_eq("end_valid", 256'(tb_if.valid_out), 256'(0));
        check_model("end");
        step();
        check_eq("done_pulse", 256'(tb_if.done), 256'(0));
    endtask

    task automatic drain_ignored(input string tag);
        tb_if.ready_in  = 1'b1;
        tb_if.drain_req = 1'b1;
        step();
        tb_if.drain_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq({tag, "_busy"}, 256'(tb_if.busy), 256'(0));
            check_eq({tag, "_valid"}, 256'(tb_if.valid_out), 256'(0));
            check_eq({tag, "_done"}, 256'(tb_if.done), 256'(0));
            step();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        tb_if.tracing    = 1'b0;
        tb_if.valid_in   = 1'b0;
        tb_if.vector_in  = '0;
        tb_if.configId   = 8'hFF;
        tb_if.configData = 8'd0;
        tb_if.drain_req  = 1'b0;
        tb_if.ready_in   = 1'b0;
        model_mode       = 1'b0;
        model_ovf        = 1'b0;
        step();
        step();
        reset = 1'b0;

        check_eq("rst_count", 256'(tb_if.count_out), 256'(0));
        check_eq("rst_ovf", 256'(tb_if.overflow), 256'(0));
        check_eq("rst_busy", 256'(tb_if.busy), 256'(0));
        check_eq("rst_valid", 256'(tb_if.valid_out), 256'(0));
        check_eq("rst_done", 256'(tb_if.done), 256'(0));
        check_eq("rst_vec", 256'(tb_if.vector_out), 256'(0));

        // Basic drain
        capture_seq(10, 3);
        check_model("basic");
        drain(0, 1'b0);

        // Circular wrap keeps the newest four
        do_reset();
        capture_seq(1, 6);
        check_model("wrap");
        drain(0, 1'b0);

        // Stop mode keeps the oldest four
        do_reset();
        set_mode(1'b1);
        capture_seq(1, 6);
        check_model("stop");
        drain(0, 1'b0);

        // Backpressure
        do_reset();
        capture_seq(10, 2);
        drain(5, 1'b0);

        // Reset while presenting
        do_reset();
        capture_seq(10, 3);
        tb_if.tracing   = 1'b0;
        tb_if.ready_in  = 1'b0;
        tb_if.drain_req = 1'b1;
        step();
        tb_if.drain_req = 1'b0;
        step();
        check_eq("mid_valid", 256'(tb_if.valid_out), 256'(1));
        do_reset();
        check_eq("mid_rst_valid", 256'(tb_if.valid_out), 256'(0));
        check_eq("mid_rst_busy", 256'(tb_if.busy), 256'(0));
        check_eq("mid_rst_vec", 256'(tb_if.vector_out), 256'(0));
        check_model("mid_rst");
        drain_ignored("post_rst");

        // Ignored inputs
        capture_seq(20, 2);
        tb_if.tracing   = 1'b0;
        tb_if.valid_in  = 1'b1;
        tb_if.vector_in = make_vec(77);
        step();
        tb_if.valid_in  = 1'b0;
        check_model("notrace");
        drain(0, 1'b1);
        capture_seq(30, 2);
        tb_if.tracing = 1'b1;
        drain_ignored("trace_hi");
        check_model("trace_hi");
        drain(1, 1'b0);

        // Randomized rounds
        do_reset();
        for (int iter = 0; iter < 40; iter++) begin
            int ncyc;
            if ($urandom_range(0, 3) == 0) set_mode(1'($urandom_range(0, 1)));
            ncyc = $urandom_range(0, 9);
            for (int c = 0; c < ncyc; c++) begin
                vector_t v;
                bit      tr;
                bit      vi;
                tr = ($urandom_range(0, 3) != 0);
                vi = 1'($urandom_range(0, 1));
                v  = make_vec(100 * iter + c);
                tb_if.tracing   = tr;
                tb_if.valid_in  = vi;
                tb_if.vector_in = v;
                step();
                if (tr && vi) model_push(v);
                check_model("rand");
            end
            tb_if.tracing  = 1'b0;
            tb_if.valid_in = 1'b0;
            if (model_q.size() > 0) drain($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            else drain_ignored("rand_empty");
            if ($urandom_range(0, 7) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Sits directly downstream of the data packer and captures each full N-lane vector it emits (valid_out/vector_out) into an on-chip circular buffer while tracing is active.
- Once tracing stops, the host requests a drain and the buffer replays the stored vectors oldest-first over a valid/ready handshake.
- Buffer mode (circular overwrite vs stop-when-full) is set through the shared configId/configData bus.

Parameters:
- N, 8, lanes per vector; must match the packer.
- DATA_WIDTH, 32, bits per lane.
- DEPTH, 16, vectors stored; power of two, at least 2.
- PERSONAL_CONFIG_ID, 0, configId value addressed to this block.
- INITIAL_MODE, 0, mode after reset: 0 = circular overwrite, 1 = stop when full.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- tracing  input  1  capture enable.
- valid_in  input  1  packer output valid.
- vector_in  input  DATA_WIDTH x N  packer output vector.
- configId  input  8  config target id.
- configData  input  8  config payload; bit0 = mode.
- drain_req  input  1  start-readout pulse.
- ready_in  input  1  consumer ready.
- vector_out  output  DATA_WIDTH x N  drained vector.
- valid_out  output  1  vector_out valid.
- count_out  output  $clog2(DEPTH)+1  vectors currently stored.
- overflow  output  1  sticky flag: data was lost.
- busy  output  1  drain in progress.
- done  output  1  one-cycle pulse when the drain empties the buffer.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - wr_ptr = rd_ptr = 0, count_out = 0.
  - overflow = 0, busy = 0, valid_out = 0, done = 0, vector_out = 0.
  - mode = INITIAL_MODE, state = CAPTURE.
  - RAM contents are not cleared.
  - Reset mid-drain: valid_out = 0 on the next edge and all stored data is discarded.
- Config: when configId == PERSONAL_CONFIG_ID, mode <= configData[0] in any state. A mode change does not alter pointers or count.
- States: CAPTURE, READ, PRESENT.
- CAPTURE, write condition is tracing & valid_in:
  - count < DEPTH: write vector_in at wr_ptr; wr_ptr++ (wraps modulo DEPTH); count++.
  - count == DEPTH, mode 0: overwrite at wr_ptr; wr_ptr++ and rd_ptr++; count unchanged; overflow <= 1.
  - count == DEPTH, mode 1: drop the vector, no pointer change, overflow <= 1.
- CAPTURE, drain start: drain_req & ~tracing & count > 0 -> READ, busy <= 1. Accepted only in CAPTURE.
  - drain_req with count == 0 is ignored: no busy, no done.
  - drain_req while tracing = 1 is ignored.
- READ (one cycle): RAM read of rd_ptr is issued -> PRESENT.
- PRESENT:
  - vector_out = RAM[rd_ptr], valid_out = 1.
  - vector_out is held stable while ready_in = 0.
  - On valid_out & ready_in: rd_ptr++, count--, valid_out <= 0.
  - After the handshake, if the new count > 0 -> READ; else -> CAPTURE, busy <= 0, done <= 1 for one cycle.
- Latency and throughput:
  - First valid_out is asserted 2 cycles after the accepted drain_req edge.
  - Each subsequent word is asserted 2 cycles after the previous handshake, i.e. at most 1 word per 2 cycles.
- During READ/PRESENT, valid_in is ignored: no write and no overflow update. tracing has no effect until the drain completes.
- Same cycle as a capture write, drain_req is ignored, because a write requires tracing = 1.
- count_out always equals the number of valid stored vectors and never exceeds DEPTH.
- Only a reset clears overflow; a drain does not.

Decomposition:
- Package trace_pkg:
  - state enum {CAPTURE, READ, PRESENT}.
  - Mode constants MODE_CIRCULAR = 0, MODE_STOP = 1.
  - Vector typedef parameterised by DATA_WIDTH and N.
- Sub-module trace_ram:
  - Simple dual-port RAM, DEPTH x (N*DATA_WIDTH).
  - One write port, one read port with a registered read output (1-cycle read).
  - No reset, so it infers block RAM.
- Control FSM and pointers live in trace_buffer.

Test Plan:
All scenarios use N = 8, DATA_WIDTH = 32, DEPTH = 4, and lane0 = sequence value.
1. Basic drain: reset, tracing = 1, write 3 vectors (10, 11, 12), tracing = 0, drain_req, ready_in = 1 -> valid_out at cycles +2, +4, +6 carrying 10, 11, 12; count 3 -> 0; done pulses once; overflow = 0.
2. Circular wrap: mode 0, write 1..6 -> count = 4, overflow = 1; drain yields 3, 4, 5, 6.
3. Stop mode: configId = PERSONAL_CONFIG_ID, configData = 1, then write 1..6 -> drain yields 1, 2, 3, 4; overflow = 1.
4. Backpressure: drain with ready_in held low for 5 cycles after the first valid -> vector_out stays 10 and valid_out stays 1 throughout; count does not change until ready_in rises.
5. Reset mid-drain: assert reset while in PRESENT -> next cycle valid_out = 0, count = 0, busy = 0; a following drain_req produces no output and no done.
6. Ignored inputs:
   - valid_in with tracing = 0 -> count unchanged.
   - valid_in during a drain -> count unchanged, no overflow.
   - drain_req while tracing = 1 -> busy stays 0.
